// File: rtl/ibus_fetch_bridge_pkg.sv
// Shared types for the instruction fetch bridge: bus structs, FSM states, line geometry.
// Pure declarations; no latency or backpressure of its own.
package ibus_fetch_bridge_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;

  localparam int IBUF_LINE_BYTES = 8;
  localparam int IBUF_OFS_W      = $clog2(IBUF_LINE_BYTES);
  localparam int IBUF_TAG_W      = 64 - IBUF_OFS_W;

  typedef logic [IBUF_TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  function automatic tag_t addr_tag(input u64 a);
    return a[63:IBUF_OFS_W];
  endfunction

  function automatic u64 line_addr(input u64 a);
    return {a[63:IBUF_OFS_W], {IBUF_OFS_W{1'b0}}};
  endfunction

  // addr[2] picks the upper instruction of the doubleword
  function automatic u32 word_sel(input u64 line, input logic hi);
    return hi ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/ibus_fetch_bridge_if.sv
// Fetch-side handshake plus single-beat memory read port of the fetch bridge.
// Wiring only; master = fetch/memory side, slave = bridge.
interface ibus_fetch_bridge_if;
  import ibus_fetch_bridge_pkg::*;

  ibus_req_t  ibus_req;
  ibus_resp_t ibus_resp;
  logic       inv;
  logic       mreq_valid;
  u64         mreq_addr;
  logic       mresp_ready;
  u64         mresp_data;

  modport master (
    output ibus_req, inv, mresp_ready, mresp_data,
    input  ibus_resp, mreq_valid, mreq_addr
  );

  modport slave (
    input  ibus_req, inv, mresp_ready, mresp_data,
    output ibus_resp, mreq_valid, mreq_addr
  );

endinterface

// File: rtl/ibus_fetch_bridge_line_buf.sv
// One-entry doubleword line buffer: tag/data/valid, combinational hit compare and word select.
// Fill takes effect next cycle; no backpressure, a fill is always accepted.
module ibus_fetch_bridge_line_buf
  import ibus_fetch_bridge_pkg::*;
#(
  parameter bit ENABLE_BUF = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inv,
  input  logic i_miss_busy,
  input  tag_t i_lookup_tag,
  input  logic i_fill,
  input  tag_t i_fill_tag,
  input  u64   i_fill_data,
  input  logic i_word_hi,
  output logic o_hit,
  output u32   o_word
);

  logic r_valid;
  tag_t r_tag;
  u64   r_data;
  logic r_inv_pend;

  // Data is written even when an invalidate blocks the valid bit, so the
  // in-flight request can still be answered from it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_tag      <= '0;
      r_data     <= '0;
      r_inv_pend <= 1'b0;
    end else begin
      if (i_fill) begin
        r_data     <= i_fill_data;
        r_tag      <= i_fill_tag;
        r_valid    <= !(i_inv || r_inv_pend);
        r_inv_pend <= 1'b0;
      end else begin
        if (i_inv) begin
          r_valid <= 1'b0;
        end
        r_inv_pend <= i_miss_busy && (r_inv_pend || i_inv);
      end
    end
  end

  assign o_hit  = ENABLE_BUF && r_valid && !i_inv && (r_tag == i_lookup_tag);
  assign o_word = word_sel(r_data, i_word_hi);

endmodule

// File: rtl/ibus_fetch_bridge.sv
// Fetch-side bridge: serves ibus requests from a one-line buffer or a single-beat 64-bit memory read.
// Latency 2 cycles on a hit, 2 + memory wait on a miss; fetch is held by withholding data_ok, memory by mresp_ready.
module ibus_fetch_bridge
  import ibus_fetch_bridge_pkg::*;
#(
  parameter bit ENABLE_BUF     = 1'b1,
  parameter int MEM_BASE_CHECK = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  ibus_fetch_bridge_if.slave  io_bus,
  output u32                  o_hit_cnt,
  output u32                  o_miss_cnt
);

  if (MEM_BASE_CHECK != 0) begin : g_param_chk
    $error("MEM_BASE_CHECK is reserved and must be 0");
  end

  bridge_state_t r_state;
  u64            r_req_addr;
  u32            r_hit_cnt;
  u32            r_miss_cnt;
  logic          r_mreq_valid;
  u64            r_mreq_addr;
  ibus_resp_t    r_resp;

  logic w_hit;
  logic w_fill;
  logic w_req_match;
  u32   w_word;

  assign w_fill      = (r_state == MISS) && io_bus.mresp_ready;
  assign w_req_match = io_bus.ibus_req.valid && (io_bus.ibus_req.addr == r_req_addr);

  ibus_fetch_bridge_line_buf #(
    .ENABLE_BUF (ENABLE_BUF)
  ) u_line_buf (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_inv        (io_bus.inv),
    .i_miss_busy  (r_state == MISS),
    .i_lookup_tag (addr_tag(io_bus.ibus_req.addr)),
    .i_fill       (w_fill),
    .i_fill_tag   (addr_tag(r_req_addr)),
    .i_fill_data  (io_bus.mresp_data),
    .i_word_hi    (r_req_addr[2]),
    .o_hit        (w_hit),
    .o_word       (w_word)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_req_addr   <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_mreq_valid <= 1'b0;
      r_mreq_addr  <= '0;
      r_resp       <= '0;
    end else begin
      r_resp <= '0;
      case (r_state)
        IDLE: begin
          if (io_bus.ibus_req.valid) begin
            r_req_addr <= io_bus.ibus_req.addr;
            if (w_hit) begin
              r_state   <= RESP;
              r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
              r_state      <= MISS;
              r_mreq_valid <= 1'b1;
              r_mreq_addr  <= line_addr(io_bus.ibus_req.addr);
              r_miss_cnt   <= r_miss_cnt + 32'd1;
            end
          end
        end
        MISS: begin
          if (io_bus.mresp_ready) begin
            r_mreq_valid <= 1'b0;
            r_state      <= RESP;
          end
        end
        RESP: begin
          // A redirected or dropped request gets no response; IDLE re-evaluates it.
          if (w_req_match) begin
            r_resp <= '{addr_ok: 1'b1, data_ok: 1'b1, data: w_word};
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.ibus_resp  = r_resp;
  assign io_bus.mreq_valid = r_mreq_valid;
  assign io_bus.mreq_addr  = r_mreq_addr;
  assign o_hit_cnt         = r_hit_cnt;
  assign o_miss_cnt        = r_miss_cnt;

endmodule

// File: tb/tb_ibus_fetch_bridge.sv
// Bench for ibus_fetch_bridge: directed vector table, redirect/reset/wrap sequences, and
// randomized fetches checked against a transaction-level buffer model.
module tb_ibus_fetch_bridge;
  import ibus_fetch_bridge_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  u32   hit_cnt;
  u32   miss_cnt;

  ibus_fetch_bridge_if bus ();

  ibus_fetch_bridge #(
    .ENABLE_BUF     (1'b1),
    .MEM_BASE_CHECK (0)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .io_bus     (bus),
    .o_hit_cnt  (hit_cnt),
    .o_miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: what the buffer holds and how many hits/misses there have been.
  logic        m_valid  = 1'b0;
  logic [60:0] m_tag    = '0;
  u64          m_line   = '0;
  u32          m_hits   = '0;
  u32          m_misses = '0;

  typedef struct {
    u64 addr;
    bit inv_first;
    bit inv_req;
    bit inv_at_ready;
    int wait_n;
    u64 mdata;
    bit exp_miss;
    u32 exp_data;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic bit model_is_hit(input u64 addr);
    return m_valid && (m_tag == addr[63:3]);
  endfunction

  function automatic u32 model_word(input u64 addr, input u64 mdata);
    u64 line;
    line = model_is_hit(addr) ? m_line : mdata;
    return addr[2] ? line[63:32] : line[31:0];
  endfunction

  task automatic model_commit(input u64 addr, input u64 mdata, input bit inv_r);
    if (model_is_hit(addr)) begin
      m_hits = m_hits + 32'd1;
    end else begin
      m_misses = m_misses + 32'd1;
      m_line   = mdata;
      m_tag    = addr[63:3];
      m_valid  = !inv_r;
    end
  endtask

  task automatic pulse_inv();
    bus.inv = 1'b1;
    @(posedge clk); #1;
    bus.inv = 1'b0;
    m_valid = 1'b0;
  endtask

  // Present one request, act as memory, wait for data_ok and check the outcome.
  task automatic do_fetch(input string nm, input u64 addr, input bit inv_req, input bit inv_r,
                          input int wait_n, input u64 mdata, input bit exp_miss, input u32 exp_data);
    int cyc = 0;
    int mv = 0;
    bit got = 1'b0;
    bit saw = 1'b0;
    bit addr_bad = 1'b0;
    bit pair_bad = 1'b0;
    u32 dat = '0;
    bus.ibus_req = '{valid: 1'b1, addr: addr};
    bus.inv = inv_req;
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      bus.mresp_ready = 1'b0;
      bus.inv = 1'b0;
      if (bus.ibus_resp.addr_ok !== bus.ibus_resp.data_ok) pair_bad = 1'b1;
      if (bus.mreq_valid === 1'b1) begin
        saw = 1'b1;
        mv++;
        if (bus.mreq_addr !== {addr[63:3], 3'b000}) addr_bad = 1'b1;
        if (mv == wait_n) begin
          bus.mresp_ready = 1'b1;
          bus.mresp_data  = mdata;
          bus.inv         = inv_r;
        end
      end
      if (bus.ibus_resp.data_ok === 1'b1) begin
        got = 1'b1;
        dat = bus.ibus_resp.data;
      end
    end
    bus.ibus_req.valid = 1'b0;
    check({nm, " data_ok seen"}, 64'(got), 64'(1));
    check({nm, " latency"}, 64'(cyc), 64'(exp_miss ? (2 + wait_n) : 2));
    check({nm, " mreq issued"}, 64'(saw), 64'(exp_miss));
    if (exp_miss) check({nm, " mreq_addr bad"}, 64'(addr_bad), 64'(0));
    check({nm, " addr_ok/data_ok split"}, 64'(pair_bad), 64'(0));
    check({nm, " data"}, 64'(dat), 64'(exp_data));
    check({nm, " hit_cnt"}, 64'(hit_cnt), 64'(m_hits));
    check({nm, " miss_cnt"}, 64'(miss_cnt), 64'(m_misses));
  endtask

  task automatic model_fetch(input string nm, input u64 addr, input bit inv_req, input bit inv_r,
                             input int wait_n, input u64 mdata);
    bit miss;
    u32 w;
    if (inv_req) m_valid = 1'b0;
    miss = !model_is_hit(addr);
    w    = model_word(addr, mdata);
    model_commit(addr, mdata, inv_r);
    do_fetch(nm, addr, inv_req, inv_r, wait_n, mdata, miss, w);
  endtask

  // Request a1, move to a2 while the a1 line is still being read from memory.
  task automatic redirect_seq(input string nm, input u64 a1, input u64 a2, input u64 l1, input u64 l2);
    int cyc = 0;
    int run = 0;
    int txns = 0;
    bit got = 1'b0;
    u32 dat = '0;
    u64 second = '0;
    bit miss1;
    bit miss2;
    u32 w2;
    miss1 = !model_is_hit(a1);
    model_commit(a1, l1, 1'b0);
    miss2 = !model_is_hit(a2);
    w2    = model_word(a2, l2);
    model_commit(a2, l2, 1'b0);
    bus.ibus_req = '{valid: 1'b1, addr: a1};
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      bus.mresp_ready = 1'b0;
      if (cyc == 2) bus.ibus_req.addr = a2;
      if (bus.mreq_valid === 1'b1) begin
        run++;
        if (run == 1) begin
          txns++;
          if (txns == 2) second = bus.mreq_addr;
        end
        if (run == 2) begin
          bus.mresp_ready = 1'b1;
          bus.mresp_data  = (bus.mreq_addr == {a1[63:3], 3'b000}) ? l1 : l2;
        end
      end else begin
        run = 0;
      end
      if (bus.ibus_resp.data_ok === 1'b1) begin
        got = 1'b1;
        dat = bus.ibus_resp.data;
      end
    end
    bus.ibus_req.valid = 1'b0;
    check({nm, " data_ok seen"}, 64'(got), 64'(1));
    check({nm, " data_ok cycle"}, 64'(cyc), 64'(miss2 ? 8 : 6));
    check({nm, " memory reads"}, 64'(txns), 64'(int'(miss1) + int'(miss2)));
    if (miss2) check({nm, " second mreq_addr"}, second, {a2[63:3], 3'b000});
    check({nm, " data"}, 64'(dat), 64'(w2));
    check({nm, " hit_cnt"}, 64'(hit_cnt), 64'(m_hits));
    check({nm, " miss_cnt"}, 64'(miss_cnt), 64'(m_misses));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ibus_req    = '{valid: 1'b0, addr: '0};
    bus.inv         = 1'b0;
    bus.mresp_ready = 1'b0;
    bus.mresp_data  = '0;

    vecs[0]  = '{64'h8000_0000, 0, 0, 0, 3, 64'h1111_2222_3333_4444, 1, 32'h3333_4444};
    vecs[1]  = '{64'h8000_0004, 0, 0, 0, 1, 64'h0,                   0, 32'h1111_2222};
    vecs[2]  = '{64'h8000_0000, 0, 0, 0, 1, 64'h0,                   0, 32'h3333_4444};
    vecs[3]  = '{64'h8000_0008, 0, 0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 1, 32'hCCCC_DDDD};
    vecs[4]  = '{64'h8000_000C, 0, 0, 0, 1, 64'h0,                   0, 32'hAAAA_BBBB};
    vecs[5]  = '{64'h8000_0004, 0, 0, 0, 2, 64'h1111_2222_3333_4444, 1, 32'h1111_2222};
    vecs[6]  = '{64'h8000_0004, 1, 0, 0, 1, 64'h5555_6666_7777_8888, 1, 32'h5555_6666};
    vecs[7]  = '{64'h8000_0000, 0, 0, 0, 1, 64'h0,                   0, 32'h7777_8888};
    vecs[8]  = '{64'h8000_0040, 0, 0, 1, 2, 64'h9999_AAAA_BBBB_CCCC, 1, 32'hBBBB_CCCC};
    vecs[9]  = '{64'h8000_0044, 0, 0, 0, 1, 64'h9999_AAAA_BBBB_CCCC, 1, 32'h9999_AAAA};
    vecs[10] = '{64'h8000_0040, 0, 0, 0, 1, 64'h0,                   0, 32'hBBBB_CCCC};
    vecs[11] = '{64'h8000_0044, 0, 1, 0, 1, 64'hDEAD_BEEF_0BAD_F00D, 1, 32'hDEAD_BEEF};

    repeat (2) @(posedge clk);
    #1;
    check("reset mreq_valid", 64'(bus.mreq_valid), 64'(0));
    check("reset mreq_addr", bus.mreq_addr, 64'h0);
    check("reset addr_ok", 64'(bus.ibus_resp.addr_ok), 64'(0));
    check("reset data_ok", 64'(bus.ibus_resp.data_ok), 64'(0));
    check("reset data", 64'(bus.ibus_resp.data), 64'(0));
    check("reset hit_cnt", 64'(hit_cnt), 64'(0));
    check("reset miss_cnt", 64'(miss_cnt), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].inv_first) pulse_inv();
      if (vecs[i].inv_req) m_valid = 1'b0;
      model_commit(vecs[i].addr, vecs[i].mdata, vecs[i].inv_at_ready);
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].inv_req, vecs[i].inv_at_ready,
               vecs[i].wait_n, vecs[i].mdata, vecs[i].exp_miss, vecs[i].exp_data);
    end

    redirect_seq("redirect far", 64'h8000_0010, 64'h8000_0100,
                 64'h0101_0202_0303_0404, 64'h0A0B_0C0D_0E0F_1011);
    redirect_seq("redirect same line", 64'h8000_0020, 64'h8000_0024,
                 64'h2424_2424_2020_2020, 64'h0);

    for (int i = 0; i < 60; i++) begin
      u64 addr;
      bit inv_req;
      bit inv_r;
      addr    = 64'h8000_0000 + 64'($urandom_range(0, 7)) * 64'd8 + 64'($urandom_range(0, 1)) * 64'd4;
      inv_req = ($urandom_range(0, 7) == 0);
      inv_r   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) pulse_inv();
      model_fetch($sformatf("rand%0d", i), addr, inv_req, inv_r, int'($urandom_range(1, 4)),
                  {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    force dut.r_miss_cnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.r_miss_cnt;
    m_misses = 32'hFFFF_FFFF;
    model_fetch("wrap", 64'h8000_0400, 1'b0, 1'b0, 2, 64'h0404_0404_0400_0400);
    check("miss_cnt wrap to zero", 64'(miss_cnt), 64'(0));

    bus.ibus_req = '{valid: 1'b1, addr: 64'h8000_0300};
    @(posedge clk); #1;
    check("mid-miss mreq_valid", 64'(bus.mreq_valid), 64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset mreq_valid", 64'(bus.mreq_valid), 64'(0));
    check("async reset mreq_addr", bus.mreq_addr, 64'h0);
    check("async reset data_ok", 64'(bus.ibus_resp.data_ok), 64'(0));
    check("async reset hit_cnt", 64'(hit_cnt), 64'(0));
    check("async reset miss_cnt", 64'(miss_cnt), 64'(0));
    bus.ibus_req.valid = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    m_valid  = 1'b0;
    m_hits   = '0;
    m_misses = '0;
    @(posedge clk); #1;
    model_fetch("post-reset", 64'h8000_0404, 1'b0, 1'b0, 1, 64'h7070_7070_0707_0707);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ibus_fetch_bridge.md
Name: ibus_fetch_bridge

Overview:
- Sits directly upstream of the program-counter/fetch stage.
- Services its ibus_req/ibus_resp instruction handshake from a single-beat 64-bit memory read port.
- Holds a one-entry doubleword line buffer, so the second instruction of an aligned 8-byte pair returns without a memory access.
- Survives fetch redirects (jump/branch/interrupt) that change the requested address mid-flight.

Parameters:
- ENABLE_BUF, 1, when 0 the line buffer never hits and every fetch goes to memory.
- MEM_BASE_CHECK, 0, reserved; must be 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ibus_req  in  ibus_req_t  from fetch: valid, addr[63:0]
- ibus_resp  out  ibus_resp_t  to fetch: addr_ok, data_ok, data[31:0]
- inv  in  1  one-cycle pulse; invalidate line buffer (fence.i)
- mreq_valid  out  1  memory read request
- mreq_addr  out  64  8-byte-aligned read address
- mresp_ready  in  1  memory returns data this cycle, single beat
- mresp_data  in  64  read data
- hit_cnt  out  32  buffer hits, wraps modulo 2^32
- miss_cnt  out  32  memory fetches issued, wraps modulo 2^32

Behaviour:
- Reset (rst_n low, async), all cleared:
  - state=IDLE; buf_valid, req_addr, hit_cnt, miss_cnt = 0.
  - mreq_valid=0, mreq_addr=0.
  - ibus_resp.addr_ok=data_ok=0, data=0.
- All outputs are registered.
- tag = addr[63:3]. Word select: data = addr[2] ? line[63:32] : line[31:0]. addr[1:0] is ignored; fetch never issues misaligned requests.
- IDLE:
  - If ibus_req.valid: capture req_addr <= ibus_req.addr.
  - Hit (ENABLE_BUF=1, buf_valid, tag matches buf_tag): go RESP, hit_cnt++.
  - Otherwise go MISS: mreq_valid<=1, mreq_addr<={tag,3'b0}, miss_cnt++.
- MISS:
  - Hold mreq_valid and mreq_addr stable until mresp_ready.
  - On mresp_ready: mreq_valid<=0; buf_data<=mresp_data, buf_tag<=req tag, buf_valid<=1 (unless an inv arrived during MISS); go RESP.
  - A memory transaction is never aborted.
- RESP: lasts exactly one cycle.
  - If ibus_req.valid and ibus_req.addr==req_addr: addr_ok=data_ok=1 for one cycle, data=selected word.
  - Otherwise (redirected or dropped): no response.
  - Next state IDLE.
  - After any response the bridge returns to IDLE and re-evaluates the (possibly new) request.
- Latency, request-valid cycle to data_ok cycle: hit = 2 cycles; miss = 2 + memory wait cycles.
- Redirect while in MISS: the in-flight line is still filled into the buffer (unless inv). The stale response is suppressed in RESP. The new address is then serviced from IDLE; it hits if it is in the same doubleword.
- inv:
  - Clears buf_valid next cycle in any state.
  - inv in the same cycle as the MISS fill: inv wins; buffer stays invalid, but RESP still answers the current request from the captured data.
  - inv in IDLE in the same cycle as a hit-eligible request: treated as a miss.
- Fetch holds valid high until it samples data_ok, then drops valid or moves addr. A fresh request at an unchanged address after data_ok is a new fetch (normal sequential flow never repeats an address).
- Counters increment once per accepted IDLE decision. They wrap from 0xFFFF_FFFF to 0 silently.
- ibus_resp.addr_ok and data_ok are always asserted together.

Decomposition:
- Shared package common:
  - add typedef bridge_state_t {IDLE, MISS, RESP};
  - add constant IBUF_LINE_BYTES=8;
  - reuse existing ibus_req_t/ibus_resp_t and u64/u32.
- One natural sub-module: ibus_line_buf (tag/data/valid registers, hit compare, word select, inv handling). The FSM and counters stay in the top module.

Test Plan:
- Reset then request 0x8000_0000, memory ready after 3 cycles with data 0x1111_2222_3333_4444 -> mreq_addr=0x8000_0000 and data_ok with data=0x3333_4444; miss_cnt=1.
- Follow-up request 0x8000_0004 -> no mreq_valid; data_ok 2 cycles later with data=0x1111_2222; hit_cnt=1.
- Miss on 0x8000_0010, then fetch redirects to 0x8000_0100 during MISS -> no data_ok for 0x10; line 0x10 buffered; second miss issued for 0x100; data_ok carries the 0x100 word; miss_cnt=2.
- inv pulse after filling 0x8000_0000, then request 0x8000_0004 -> treated as miss; mreq_valid asserted.
- inv coincident with mresp_ready -> current request answered; an immediate same-line request misses.
- Preload miss_cnt=0xFFFF_FFFF via forced misses, one more miss -> miss_cnt=0. Assert rst_n low mid-MISS -> mreq_valid=0, state IDLE, buf_valid=0 immediately.
